// File: rtl/lock_pkg.sv
// Shared definitions for the password lock controller.
//   lock_state_e      : controller state (LOCKED, OPEN, LOCKOUT)
//   DEF_*             : default parameter values used by the top module
package lock_pkg;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } lock_state_e;

    localparam int DEF_PW_WIDTH    = 6;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_LOCK_CYCLES = 16;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter that times the LOCKOUT interval.
//   clk, rst_n : clock, asynchronous active-low reset (counter clears to 0)
//   load_i     : load LOCK_CYCLES into the counter
//   done_o     : high during the final cycle of the interval (count <= 1),
//                so the owner can leave LOCKOUT on the edge that takes the
//                count to zero
module lockout_timer #(
    parameter  int LOCK_CYCLES = 16,
    localparam int LW          = $clog2(LOCK_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic done_o
);

    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;

    // Load has priority; otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LW'(LOCK_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q <= LW'(1));

endmodule

// File: rtl/password_lock_ctrl.sv
// Password lock controller: stores a password, checks entered codes, counts
// failed attempts and holds a timed lockout (alarm) after MAX_TRIES misses.
// Password changes are accepted only while open.
//
// Strobe semantics: enter and set are one-cycle pulses with no back-pressure.
// Every cycle a strobe is high counts as one request; pw_in is sampled in
// that cycle. All responses are registered and appear one cycle later.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   pw_in        : code from switches
//   enter        : try code (LOCKED) / relock (OPEN)
//   set          : store pw_in as the new password (OPEN only)
//   npw          : stored password
//   status       : one-cycle pulse, set accepted
//   set_err      : one-cycle pulse, set rejected
//   unlocked     : high while OPEN
//   alarm        : high while LOCKOUT
//   tries_left   : remaining attempts before lockout
//   dbg_state_o  : current controller state, for observation
module password_lock_ctrl
    import lock_pkg::*;
#(
    parameter  int                  PW_WIDTH    = DEF_PW_WIDTH,
    parameter  logic [PW_WIDTH-1:0] DEFAULT_PW  = '0,
    parameter  int                  MAX_TRIES   = DEF_MAX_TRIES,
    parameter  int                  LOCK_CYCLES = DEF_LOCK_CYCLES,
    localparam int                  TW          = $clog2(MAX_TRIES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PW_WIDTH-1:0] pw_in,
    input  logic                enter,
    input  logic                set,
    output logic [PW_WIDTH-1:0] npw,
    output logic                status,
    output logic                set_err,
    output logic                unlocked,
    output logic                alarm,
    output logic [TW-1:0]       tries_left,
    output lock_state_e         dbg_state_o
);

    localparam logic [TW-1:0] TRIES_FULL = TW'(MAX_TRIES);

    lock_state_e         state_q,   state_d;
    logic [PW_WIDTH-1:0] npw_q,     npw_d;
    logic [TW-1:0]       tries_q,   tries_d;
    logic                status_q,  status_d;
    logic                set_err_q, set_err_d;
    logic                tmr_load;
    logic                tmr_done;

    lockout_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        npw_d     = npw_q;
        tries_d   = tries_q;
        status_d  = 1'b0;
        set_err_d = 1'b0;
        tmr_load  = 1'b0;
        case (state_q)
            LOCKED: begin
                // set is refused here but a simultaneous enter still counts.
                if (set) begin
                    set_err_d = 1'b1;
                end
                if (enter) begin
                    if (pw_in == npw_q) begin
                        state_d = OPEN;
                        tries_d = TRIES_FULL;
                    end else if (tries_q <= TW'(1)) begin
                        state_d  = LOCKOUT;
                        tries_d  = '0;
                        tmr_load = 1'b1;
                    end else begin
                        tries_d = tries_q - TW'(1);
                    end
                end
            end
            OPEN: begin
                // set wins over a simultaneous enter.
                if (set) begin
                    npw_d    = pw_in;
                    status_d = 1'b1;
                end else if (enter) begin
                    state_d = LOCKED;
                end
            end
            LOCKOUT: begin
                if (set) begin
                    set_err_d = 1'b1;
                end
                if (tmr_done) begin
                    state_d = LOCKED;
                    tries_d = TRIES_FULL;
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOCKED;
            npw_q     <= DEFAULT_PW;
            tries_q   <= TRIES_FULL;
            status_q  <= 1'b0;
            set_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            npw_q     <= npw_d;
            tries_q   <= tries_d;
            status_q  <= status_d;
            set_err_q <= set_err_d;
        end
    end

    assign npw         = npw_q;
    assign status      = status_q;
    assign set_err     = set_err_q;
    assign unlocked    = (state_q == OPEN);
    assign alarm       = (state_q == LOCKOUT);
    assign tries_left  = tries_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_password_lock_ctrl.sv
module tb_password_lock_ctrl;
  import lock_pkg::*;

  localparam int PW = 6;
  localparam int MAXT = 3;
  localparam int LCYC = 16;

  logic clk;
  logic rst_n;
  logic [PW-1:0] pw_in;
  logic enter;
  logic set;
  logic [PW-1:0] npw;
  logic status;
  logic set_err;
  logic unlocked;
  logic alarm;
  logic [1:0] tries_left;
  lock_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;

  password_lock_ctrl #(
    .PW_WIDTH(PW), .DEFAULT_PW(6'h00), .MAX_TRIES(MAXT), .LOCK_CYCLES(LCYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pw_in(pw_in), .enter(enter), .set(set),
    .npw(npw), .status(status), .set_err(set_err), .unlocked(unlocked),
    .alarm(alarm), .tries_left(tries_left), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // Lockout is tracked as an absolute cycle window: alarm is high for
  // every cycle index below lock_end.
  longint cyc;
  longint lock_end;
  bit m_open;
  logic [PW-1:0] m_pw;
  int m_tries;
  bit m_status;
  bit m_err;

  function automatic bit m_alarm();
    return cyc < lock_end;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; lock_end = 0; m_open = 0; m_pw = '0; m_tries = MAXT;
      m_status = 0; m_err = 0;
    end else begin
      bit was_alarm;
      was_alarm = m_alarm();
      cyc = cyc + 1;
      m_status = 0;
      m_err = 0;
      if (was_alarm) begin
        if (set) m_err = 1;
        if (!m_alarm()) m_tries = MAXT;
      end else if (m_open) begin
        if (set) begin
          m_pw = pw_in;
          m_status = 1;
        end else if (enter) begin
          m_open = 0;
        end
      end else begin
        if (set) m_err = 1;
        if (enter) begin
          if (pw_in == m_pw) begin
            m_open = 1;
            m_tries = MAXT;
          end else if (m_tries <= 1) begin
            m_tries = 0;
            lock_end = cyc + LCYC;
          end else begin
            m_tries = m_tries - 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle out of reset, DUT vs model.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      lock_state_e exp_st;
      exp_st = m_alarm() ? LOCKOUT : (m_open ? OPEN : LOCKED);
      chk("cmp_npw", 32'(npw), 32'(m_pw));
      chk("cmp_status", 32'(status), 32'(m_status));
      chk("cmp_set_err", 32'(set_err), 32'(m_err));
      chk("cmp_unlocked", 32'(unlocked), 32'(m_open));
      chk("cmp_alarm", 32'(alarm), 32'(m_alarm()));
      chk("cmp_tries", 32'(tries_left), 32'(m_tries));
      chk("cmp_state", 32'(dbg_state), 32'(exp_st));
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs read at that
  // point reflect the edge that sampled the strobe.
  task automatic strobe(input logic e, input logic s, input logic [PW-1:0] p);
    enter = e; set = s; pw_in = p;
    @(posedge clk); #1;
    enter = 0; set = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int alarm_cycles;
    rst_n = 0; enter = 0; set = 0; pw_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    cmp_en = 1;
    @(posedge clk); #1;

    // reset values
    chk("rst_npw", 32'(npw), 32'h00);
    chk("rst_tries", 32'(tries_left), 32'd3);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_status", 32'(status), 32'd0);

    // default password unlocks
    strobe(1, 0, 6'h00);
    chk("unlock_default", 32'(unlocked), 32'd1);

    // change password while open
    strobe(0, 1, 6'h2A);
    chk("set_npw", 32'(npw), 32'h2A);
    chk("set_status", 32'(status), 32'd1);
    idle(1);
    chk("status_one_cycle", 32'(status), 32'd0);

    // relock, unlock with new code, relock
    strobe(1, 0, 6'h00);
    chk("relock", 32'(unlocked), 32'd0);
    strobe(1, 0, 6'h2A);
    chk("unlock_new", 32'(unlocked), 32'd1);
    strobe(1, 0, 6'h00);
    chk("relock2", 32'(unlocked), 32'd0);

    // set while locked is rejected
    strobe(0, 1, 6'h15);
    chk("locked_set_err", 32'(set_err), 32'd1);
    chk("locked_set_npw", 32'(npw), 32'h2A);
    chk("locked_set_status", 32'(status), 32'd0);
    idle(1);
    chk("set_err_one_cycle", 32'(set_err), 32'd0);

    // three wrong codes -> lockout
    strobe(1, 0, 6'h01);
    chk("wrong1_tries", 32'(tries_left), 32'd2);
    strobe(1, 0, 6'h02);
    chk("wrong2_tries", 32'(tries_left), 32'd1);
    strobe(1, 0, 6'h03);
    chk("wrong3_alarm", 32'(alarm), 32'd1);
    chk("wrong3_tries", 32'(tries_left), 32'd0);

    // count alarm cycles while pressing the correct code (must be ignored)
    alarm_cycles = 0;
    while (alarm && alarm_cycles < 40) begin
      alarm_cycles++;
      strobe(1, 0, 6'h2A);
    end
    chk("lockout_len", 32'(alarm_cycles), 32'd16);
    chk("after_lock_unlocked", 32'(unlocked), 32'd0);
    chk("after_lock_tries", 32'(tries_left), 32'd3);
    strobe(1, 0, 6'h2A);
    chk("after_lock_unlock", 32'(unlocked), 32'd1);

    // set and enter together while open: set wins
    strobe(1, 1, 6'h3F);
    chk("set_enter_npw", 32'(npw), 32'h3F);
    chk("set_enter_open", 32'(unlocked), 32'd1);
    chk("set_enter_status", 32'(status), 32'd1);

    // relock, lock out, then async reset mid-lockout
    strobe(1, 0, 6'h00);
    strobe(1, 0, 6'h01);
    strobe(1, 0, 6'h02);
    strobe(1, 0, 6'h03);
    idle(3);
    chk("pre_reset_alarm", 32'(alarm), 32'd1);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("async_rst_alarm", 32'(alarm), 32'd0);
    chk("async_rst_tries", 32'(tries_left), 32'd3);
    chk("async_rst_npw", 32'(npw), 32'h00);
    chk("async_rst_unlocked", 32'(unlocked), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      logic e, s;
      logic [PW-1:0] p;
      e = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0, 1: p = m_pw;
        2: p = PW'($urandom_range(0, 3));
        default: p = PW'($urandom_range(0, 63));
      endcase
      strobe(e, s, p);
    end

    cmp_en = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
